// File: rtl/sensor_board_scanner_pkg.sv
// Shared constants and scan FSM encoding for the sensor-board scanner.
package sensor_board_scanner_pkg;

    localparam int          SQUARES     = 32;
    localparam logic [15:0] SENSOR_ADDR = 16'h1001;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } scan_state_e;

    // Bits arrive MSB first: shift index 0 lands in the top square.
    function automatic logic [4:0] sq_bit(input logic [4:0] idx);
        return 5'(SQUARES - 1) - idx;
    endfunction

endpackage

// File: rtl/sensor_board_scanner_debounce.sv
// Debounce of complete scan words: board only follows a word seen on enough consecutive scans.
module sensor_debounce
    import sensor_board_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               done_i,
    input  logic [SQUARES-1:0] raw_i,
    output logic [SQUARES-1:0] board_o,
    output logic               board_valid_o,
    output logic               changed_o
);

    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

    logic [SQUARES-1:0] last_raw_q;
    logic [SQUARES-1:0] board_q;
    logic [3:0]         stable_cnt_q;
    logic               valid_q;
    logic               changed_q;

    logic               same_d;
    logic [3:0]         stable_cnt_d;
    logic               accept_d;

    always_comb begin
        same_d       = (raw_i == last_raw_q);
        stable_cnt_d = 4'd1;
        if (same_d) begin
            stable_cnt_d = (stable_cnt_q >= DEB_MAX) ? DEB_MAX : stable_cnt_q + 4'd1;
        end
        // The very first word is taken unconditionally so the board is never stale-invalid for long.
        accept_d = ((stable_cnt_d >= DEB_MAX) && (raw_i != board_q)) || !valid_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_raw_q   <= '0;
            board_q      <= '0;
            stable_cnt_q <= '0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (done_i) begin
                stable_cnt_q <= stable_cnt_d;
                if (!same_d) begin
                    last_raw_q <= raw_i;
                end
                if (accept_d) begin
                    board_q   <= raw_i;
                    valid_q   <= 1'b1;
                    changed_q <= 1'b1;
                end
            end
        end
    end

    assign board_o       = board_q;
    assign board_valid_o = valid_q;
    assign changed_o     = changed_q;

endmodule

// File: rtl/sensor_board_scanner.sv
// Scans a 32-stage parallel-in shift-register chain and publishes a debounced occupancy word.
module sensor_board_scanner
    import sensor_board_scanner_pkg::*;
#(
    parameter int CLK_DIV        = 50,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scan_en_i,
    input  logic        sr_data_i,
    output logic        sr_load_n_o,
    output logic        sr_clk_o,
    output logic [31:0] board_o,
    output logic        board_valid_o,
    output logic        changed_o,
    output logic [2:0]  state_o
);

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    scan_state_e        state_q, state_d;
    logic [9:0]         div_q, div_d;
    logic [4:0]         idx_q, idx_d;
    logic [SQUARES-1:0] raw_q, raw_d;
    logic               sync1_q, sync2_q;
    logic               sr_load_n_q, sr_load_n_d;
    logic               sr_clk_q, sr_clk_d;
    logic               div_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sr_data_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        raw_d    = raw_q;
        div_last = (div_q == DIV_LAST);
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (scan_en_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (div_last) begin
                    div_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SHIFT_LO;
                end else begin
                    div_d = div_q + 10'd1;
                end
            end
            ST_SHIFT_LO: begin
                // Sample at the end of the low phase, furthest from the previous shift edge.
                if (div_last) begin
                    raw_d[sq_bit(idx_q)] = sync2_q;
                    div_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    div_d = div_q + 10'd1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (idx_q == 5'(SQUARES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 10'd1;
                end
            end
            ST_DONE: begin
                div_d   = '0;
                state_d = scan_en_i ? ST_LOAD : ST_IDLE;
            end
            default: begin
                div_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Strobes are decoded from the next state and registered, so they align with the state register.
        sr_load_n_d = (state_d != ST_LOAD);
        sr_clk_d    = (state_d == ST_SHIFT_HI);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            raw_q       <= '0;
            sr_load_n_q <= 1'b1;
            sr_clk_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            raw_q       <= raw_d;
            sr_load_n_q <= sr_load_n_d;
            sr_clk_q    <= sr_clk_d;
        end
    end

    sensor_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .done_i       (state_q == ST_DONE),
        .raw_i        (raw_q),
        .board_o      (board_o),
        .board_valid_o(board_valid_o),
        .changed_o    (changed_o)
    );

    assign sr_load_n_o = sr_load_n_q;
    assign sr_clk_o    = sr_clk_q;
    assign state_o     = state_q;

endmodule
